// File: rtl/mem_stage_hs_if.sv
// Memory request/acknowledge port between the MEM stage and the data memory.
// The stage drives the request side; the memory returns ack and read data.
interface mem_stage_hs_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: one variable-latency data access per instruction over a
// req/ack port, branch resolution, stall/flush handling and killed results.
module mem_stage_hs #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int WB_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              flush,
    input  logic [2:0]        m_in,
    input  logic [WB_W-1:0]   wb_in,
    input  logic [2:0]        flags_in,
    input  logic [2:0]        bcond_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [DATA_W-1:0] pcbr_in,
    input  logic [DATA_W-1:0] alu_in,
    mem_stage_hs_if.master    mem,
    output logic              stall_out,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] pc_branch,
    output logic [DATA_W-1:0] pc_ret,
    output logic [DATA_W-1:0] alu,
    output logic [WB_W-1:0]   wb,
    output logic              branch_taken
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [2:0]        m_r;
    logic [WB_W-1:0]   wb_r;
    logic [2:0]        flags_r;
    logic [2:0]        bcond_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] pcbr_r;
    logic [DATA_W-1:0] alu_r;
    logic              valid_r;
    logic              killed_r;
    logic [DATA_W-1:0] rdata_r;
    logic              load_s;
    logic              in_req_s;
    logic              out_valid_s;
    logic              cond_s;

    // flags are {zr, neg, ov}
    function automatic logic branch_cond(input logic [2:0] bc, input logic [2:0] fl);
        logic zr;
        logic neg;
        logic ov;
        logic res;
        zr  = fl[2];
        neg = fl[1];
        ov  = fl[0];
        case (bc)
            3'd0:    res = zr;
            3'd1:    res = neg & ~ov;
            3'd2:    res = ~neg & ~ov & ~zr;
            3'd3:    res = ov;
            3'd4:    res = ~zr;
            3'd5:    res = ~(neg & ~ov);
            3'd6:    res = (neg & ~ov) | zr;
            3'd7:    res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    assign in_req_s = (state_r == ST_REQ);
    assign load_s   = ~in_req_s & ~stall_in;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state: a new memory op starts only on a non-flushed load
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (load_s) begin
                    if ((m_in[1] | m_in[0]) & ~flush) begin
                        state_nx_s = ST_REQ;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_REQ: begin
                if (mem.mem_ack) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_REQ;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Pipeline slot; a flush on load inserts a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_r     <= 3'b000;
            wb_r    <= {WB_W{1'b0}};
            flags_r <= 3'b000;
            bcond_r <= 3'b000;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            pcbr_r  <= {DATA_W{1'b0}};
            alu_r   <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
        end else if (load_s) begin
            flags_r <= flags_in;
            bcond_r <= bcond_in;
            addr_r  <= addr_in;
            wdata_r <= wdata_in;
            pcbr_r  <= pcbr_in;
            alu_r   <= alu_in;
            if (flush) begin
                m_r     <= 3'b000;
                wb_r    <= {WB_W{1'b0}};
                valid_r <= 1'b0;
            end else begin
                m_r     <= m_in;
                wb_r    <= wb_in;
                valid_r <= 1'b1;
            end
        end else begin
            m_r     <= m_r;
            wb_r    <= wb_r;
            valid_r <= valid_r;
        end
    end

    // A flush that arrives mid-access cannot cancel it, so the result is killed instead
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            killed_r <= 1'b0;
        end else if (load_s) begin
            killed_r <= 1'b0;
        end else if (in_req_s & flush) begin
            killed_r <= 1'b1;
        end else begin
            killed_r <= killed_r;
        end
    end

    // Read data capture; read+write together behaves as a write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (in_req_s & mem.mem_ack & m_r[0] & ~m_r[1]) begin
            rdata_r <= mem.mem_rdata;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign out_valid_s = valid_r & ~killed_r & ~in_req_s;
    assign cond_s      = branch_cond(bcond_r, flags_r);

    assign mem.mem_req   = in_req_s;
    assign mem.mem_we    = m_r[1];
    assign mem.mem_addr  = addr_r;
    assign mem.mem_wdata = wdata_r;

    assign stall_out    = in_req_s;
    assign rdata        = rdata_r;
    assign pc_ret       = rdata_r;
    assign pc_branch    = pcbr_r;
    assign alu          = alu_r;
    assign wb           = out_valid_s ? wb_r : {WB_W{1'b0}};
    assign branch_taken = out_valid_s & m_r[2] & cond_s;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: reset, read/write handshakes, branch
// conditions, flush of an outstanding access, stall hold and async reset.
module tb_mem_stage_hs;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int WB_W   = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall_in;
    logic              flush;
    logic [2:0]        m_in;
    logic [WB_W-1:0]   wb_in;
    logic [2:0]        flags_in;
    logic [2:0]        bcond_in;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata_in;
    logic [DATA_W-1:0] pcbr_in;
    logic [DATA_W-1:0] alu_in;
    logic              stall_out;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] pc_branch;
    logic [DATA_W-1:0] pc_ret;
    logic [DATA_W-1:0] alu;
    logic [WB_W-1:0]   wb;
    logic              branch_taken;

    int nvec = 0;
    int nerr = 0;

    mem_stage_hs_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mif ();

    mem_stage_hs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WB_W(WB_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_in     (stall_in),
        .flush        (flush),
        .m_in         (m_in),
        .wb_in        (wb_in),
        .flags_in     (flags_in),
        .bcond_in     (bcond_in),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .pcbr_in      (pcbr_in),
        .alu_in       (alu_in),
        .mem          (mif.master),
        .stall_out    (stall_out),
        .rdata        (rdata),
        .pc_branch    (pc_branch),
        .pc_ret       (pc_ret),
        .alu          (alu),
        .wb           (wb),
        .branch_taken (branch_taken)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; stall_in = 1'b0; flush = 1'b0; m_in = 3'b000; wb_in = 7'h00;
        flags_in = 3'b000; bcond_in = 3'b000; addr_in = 16'h0000; wdata_in = 16'h0000;
        pcbr_in = 16'h0000; alu_in = 16'h0000;
        mif.mem_ack = 1'b0; mif.mem_rdata = 16'h0000;
        step(); step();
        rst = 1'b0;

        // reset state, no stimulus
        chk("rst_req", mif.mem_req, 1'b0);
        chk("rst_stall", stall_out, 1'b0);
        chk("rst_wb", wb, 7'h00);
        chk("rst_bt", branch_taken, 1'b0);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_alu", alu, 16'h0000);
        chk("rst_we", mif.mem_we, 1'b0);
        chk("rst_addr", mif.mem_addr, 16'h0000);

        // read at 0x0040, ack in the third request cycle
        m_in = 3'b001; wb_in = 7'h55; addr_in = 16'h0040; alu_in = 16'h1111;
        step();
        m_in = 3'b000; wb_in = 7'h00;
        chk("rd_req1", mif.mem_req, 1'b1);
        chk("rd_stall1", stall_out, 1'b1);
        chk("rd_addr", mif.mem_addr, 16'h0040);
        chk("rd_we", mif.mem_we, 1'b0);
        chk("rd_wb_early", wb, 7'h00);
        step();
        chk("rd_req2", mif.mem_req, 1'b1);
        step();
        mif.mem_ack = 1'b1; mif.mem_rdata = 16'hBEEF;
        chk("rd_req3", mif.mem_req, 1'b1);
        chk("rd_stall3", stall_out, 1'b1);
        chk("rd_rdata_pre", rdata, 16'h0000);
        step();
        mif.mem_ack = 1'b0; mif.mem_rdata = 16'h0000;
        chk("rd_req_done", mif.mem_req, 1'b0);
        chk("rd_stall_done", stall_out, 1'b0);
        chk("rd_rdata", rdata, 16'hBEEF);
        chk("rd_pcret", pc_ret, 16'hBEEF);
        chk("rd_wb", wb, 7'h55);
        chk("rd_alu", alu, 16'h1111);

        // write 0x1234 to 0x0010, ack held high so it completes in one cycle
        m_in = 3'b010; wb_in = 7'h0A; addr_in = 16'h0010; wdata_in = 16'h1234; alu_in = 16'h2222;
        mif.mem_ack = 1'b1;
        step();
        chk("wr_req", mif.mem_req, 1'b1);
        chk("wr_we", mif.mem_we, 1'b1);
        chk("wr_addr", mif.mem_addr, 16'h0010);
        chk("wr_wdata", mif.mem_wdata, 16'h1234);
        chk("wr_stall", stall_out, 1'b1);
        step();
        mif.mem_ack = 1'b0; m_in = 3'b000; wb_in = 7'h00;
        chk("wr_req_done", mif.mem_req, 1'b0);
        chk("wr_stall_done", stall_out, 1'b0);
        chk("wr_rdata", rdata, 16'hBEEF);
        chk("wr_wb", wb, 7'h0A);

        // branch conditions; flags are {zr, neg, ov}
        m_in = 3'b100; pcbr_in = 16'h0ABC; bcond_in = 3'd1; flags_in = 3'b010;
        step();
        chk("br_lt_taken", branch_taken, 1'b1);
        chk("br_target", pc_branch, 16'h0ABC);
        flags_in = 3'b011;
        step();
        chk("br_lt_ov", branch_taken, 1'b0);
        bcond_in = 3'd7; flags_in = 3'b000;
        step();
        chk("br_uncond", branch_taken, 1'b1);
        bcond_in = 3'd2;
        step();
        chk("br_gt", branch_taken, 1'b1);
        bcond_in = 3'd0;
        step();
        chk("br_eq_nz", branch_taken, 1'b0);
        bcond_in = 3'd6; flags_in = 3'b100;
        step();
        chk("br_le_zr", branch_taken, 1'b1);
        m_in = 3'b000; flags_in = 3'b100;
        for (int b = 0; b < 8; b++) begin
            bcond_in = 3'(b);
            step();
            chk("br_nobranch", branch_taken, 1'b0);
        end

        // flush while a branch+read is outstanding, ack in the second cycle
        m_in = 3'b101; wb_in = 7'h33; addr_in = 16'h0080; bcond_in = 3'd7;
        step();
        flush = 1'b1; m_in = 3'b000; wb_in = 7'h00;
        chk("fl_req1", mif.mem_req, 1'b1);
        step();
        flush = 1'b0;
        chk("fl_req2", mif.mem_req, 1'b1);
        chk("fl_addr", mif.mem_addr, 16'h0080);
        mif.mem_ack = 1'b1; mif.mem_rdata = 16'h5555;
        step();
        mif.mem_ack = 1'b0; mif.mem_rdata = 16'h0000;
        chk("fl_req_done", mif.mem_req, 1'b0);
        chk("fl_wb", wb, 7'h00);
        chk("fl_bt", branch_taken, 1'b0);

        // stall_in hold for two cycles
        bcond_in = 3'd0; flags_in = 3'b000; wb_in = 7'h11; alu_in = 16'hAAAA;
        step();
        chk("st_alu0", alu, 16'hAAAA);
        chk("st_wb0", wb, 7'h11);
        wb_in = 7'h22; alu_in = 16'hBBBB; stall_in = 1'b1;
        step();
        chk("st_alu1", alu, 16'hAAAA);
        chk("st_wb1", wb, 7'h11);
        step();
        chk("st_alu2", alu, 16'hAAAA);
        chk("st_wb2", wb, 7'h11);
        stall_in = 1'b0;
        step();
        chk("st_alu3", alu, 16'hBBBB);
        chk("st_wb3", wb, 7'h22);

        // async reset during an outstanding request
        m_in = 3'b001; addr_in = 16'h00F0; wb_in = 7'h44;
        step();
        chk("ar_req_pre", mif.mem_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_req", mif.mem_req, 1'b0);
        chk("ar_stall", stall_out, 1'b0);
        chk("ar_rdata", rdata, 16'h0000);
        chk("ar_alu", alu, 16'h0000);
        chk("ar_wb", wb, 7'h00);
        step();
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
